bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the shared system bus that fronts the slave_1/slave_2/slave_3 peripherals.
- Grants the bus round-robin and registers the granted master's mode/addr/wdata onto the shared slave bus.
- Decodes addr[15:12] into one-hot slave selects, waits for slave ready with a timeout, then returns rdata/err to the owning master.

---
 rtl/bus_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter and sequencer for the shared slave bus
module bus_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m1_req,
   input  logic        m1_valid,
   input  logic        m1_mode,
   input  logic [15:0] m1_addr,
   input  logic [7:0]  m1_wdata,
   input  logic        m2_req,
   input  logic        m2_valid,
   input  logic        m2_mode,
   input  logic [15:0] m2_addr,
   input  logic [7:0]  m2_wdata,
   output logic        m1_grant,
   output logic        m2_grant,
   output logic        m1_ready,
   output logic        m2_ready,
   output logic [7:0]  m_rdata,
   output logic        m_err,
   output logic        mode,
   output logic [15:0] addr,
   output logic [7:0]  wdata,
   output logic        valid,
   output logic        s1,
   output logic        s2,
   output logic        s3,
   input  logic [7:0]  s1_rdata,
   input  logic [7:0]  s2_rdata,
   input  logic [7:0]  s3_rdata,
   input  logic        s1_ready,
   input  logic        s2_ready,
   input  logic        s3_ready
);

   typedef enum logic [1:0] {IDLE, ADDR, ACCESS, RESP} state_t;

   localparam logic          LP_M1   = 1'b0;
   localparam logic          LP_M2   = 1'b1;
   localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] LP_SAT  = {CW{1'b1}};

   state_t        r_state, w_state_nxt;
   logic          r_owner, w_owner_nxt;
   logic          r_last, w_last_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_mode, w_mode_nxt;
   logic [15:0]   r_addr, w_addr_nxt;
   logic [7:0]    r_wdata, w_wdata_nxt;
   logic [7:0]    r_rdata, w_rdata_nxt;
   logic          r_err, w_err_nxt;

   logic          w_own_req;
   logic          w_own_valid;
   logic          w_own_mode;
   logic [15:0]   w_own_addr;
   logic [7:0]    w_own_wdata;
   logic [2:0]    w_dec;
   logic          w_dec_ok;
   logic          w_in_access;
   logic [2:0]    w_sel;
   logic          w_sel_ready;
   logic [7:0]    w_sel_rdata;
   logic          w_cnt_last;
   logic [CW-1:0] w_cnt_inc;

   // View of the current owner's request fields
   assign w_own_req   = (r_owner == LP_M2) ? m2_req   : m1_req;
   assign w_own_valid = (r_owner == LP_M2) ? m2_valid : m1_valid;
   assign w_own_mode  = (r_owner == LP_M2) ? m2_mode  : m1_mode;
   assign w_own_addr  = (r_owner == LP_M2) ? m2_addr  : m1_addr;
   assign w_own_wdata = (r_owner == LP_M2) ? m2_wdata : m1_wdata;

   // Slave decode from the latched bus address high nibble
   always_comb begin
      w_dec = 3'b000;
      case (r_addr[15:12])
         4'h0:    w_dec = 3'b001;
         4'h1:    w_dec = 3'b010;
         4'h2:    w_dec = 3'b100;
         default: w_dec = 3'b000;
      endcase
   end

   // Read data of the decoded slave
   always_comb begin
      w_sel_rdata = 8'h00;
      if (w_dec[0])
         w_sel_rdata = s1_rdata;
      else if (w_dec[1])
         w_sel_rdata = s2_rdata;
      else if (w_dec[2])
         w_sel_rdata = s3_rdata;
   end

   assign w_dec_ok    = |w_dec;
   assign w_in_access = (r_state == ACCESS);
   assign w_sel       = w_in_access ? w_dec : 3'b000;
   assign w_sel_ready = |(w_dec & {s3_ready, s2_ready, s1_ready});
   assign w_cnt_last  = (r_cnt == LP_LAST);
   assign w_cnt_inc   = (r_cnt == LP_SAT) ? r_cnt : r_cnt + CW'(1);

   // Next state, owner choice, bus latch and response capture; counter clears on any transition
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      w_cnt_nxt   = '0;
      w_mode_nxt  = r_mode;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = r_err;
      case (r_state)
         IDLE: begin
            if (m1_req || m2_req) begin
               w_state_nxt = ADDR;
               if (m1_req && m2_req)
                  w_owner_nxt = ~r_last;
               else
                  w_owner_nxt = m2_req ? LP_M2 : LP_M1;
            end
         end
         ADDR: begin
            if (w_own_valid) begin
               w_state_nxt = ACCESS;
               w_mode_nxt  = w_own_mode;
               w_addr_nxt  = w_own_addr;
               w_wdata_nxt = w_own_wdata;
            end else if (!w_own_req) begin
               w_state_nxt = IDLE;
            end else if (w_cnt_last) begin
               w_state_nxt = RESP;
               w_rdata_nxt = 8'h00;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ACCESS: begin
            if (!w_dec_ok) begin
               w_state_nxt = RESP;
               w_rdata_nxt = 8'h00;
               w_err_nxt   = 1'b1;
            end else if (w_sel_ready) begin
               w_state_nxt = RESP;
               w_rdata_nxt = w_sel_rdata;
               w_err_nxt   = 1'b0;
            end else if (w_cnt_last) begin
               w_state_nxt = RESP;
               w_rdata_nxt = 8'h00;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and datapath registers; last_grant resets to M2 so M1 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= LP_M1;
         r_last  <= LP_M2;
         r_cnt   <= '0;
         r_mode  <= 1'b0;
         r_addr  <= 16'h0000;
         r_wdata <= 8'h00;
         r_rdata <= 8'h00;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mode  <= w_mode_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign m1_grant = (r_state != IDLE) && (r_owner == LP_M1);
   assign m2_grant = (r_state != IDLE) && (r_owner == LP_M2);
   assign m1_ready = (r_state == RESP) && (r_owner == LP_M1);
   assign m2_ready = (r_state == RESP) && (r_owner == LP_M2);
   assign m_rdata  = r_rdata;
   assign m_err    = r_err;
   assign mode     = r_mode;
   assign addr     = r_addr;
   assign wdata    = r_wdata;
   assign valid    = w_in_access && w_dec_ok;
   assign s1       = w_sel[0];
   assign s2       = w_sel[1];
   assign s3       = w_sel[2];

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scoreboard bench for bus_arbiter
module tb_bus_arbiter;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m1_req = 0, m1_valid = 0, m1_mode = 0;
   logic [15:0] m1_addr = 0;
   logic [7:0]  m1_wdata = 0;
   logic        m2_req = 0, m2_valid = 0, m2_mode = 0;
   logic [15:0] m2_addr = 0;
   logic [7:0]  m2_wdata = 0;
   logic        m1_grant, m2_grant, m1_ready, m2_ready;
   logic [7:0]  m_rdata;
   logic        m_err, mode, valid, s1, s2, s3;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  s1_rdata = 0, s2_rdata = 0, s3_rdata = 0;
   logic        s1_ready = 0, s2_ready = 0, s3_ready = 0;

   bus_arbiter #(.TIMEOUT(TIMEOUT), .CW(5)) dut (
      .clk(clk), .rst(rst),
      .m1_req(m1_req), .m1_valid(m1_valid), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m2_req(m2_req), .m2_valid(m2_valid), .m2_mode(m2_mode), .m2_addr(m2_addr), .m2_wdata(m2_wdata),
      .m1_grant(m1_grant), .m2_grant(m2_grant), .m1_ready(m1_ready), .m2_ready(m2_ready),
      .m_rdata(m_rdata), .m_err(m_err), .mode(mode), .addr(addr), .wdata(wdata), .valid(valid),
      .s1(s1), .s2(s2), .s3(s3),
      .s1_rdata(s1_rdata), .s2_rdata(s2_rdata), .s3_rdata(s3_rdata),
      .s1_ready(s1_ready), .s2_ready(s2_ready), .s3_ready(s3_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       m2;
      logic [7:0] rdata;
      logic       err;
      logic       chk_rd;
   } resp_t;

   resp_t      exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [1:0] saw_ready = 2'b00;
   int         cyc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {22'd0, m1_grant, m2_grant, m1_ready, m2_ready, m_rdata, m_err,
              mode, addr, wdata, valid, s1, s2, s3};
   endfunction

   task automatic push_exp(input logic m2, input logic [7:0] rd, input logic err, input logic chk_rd);
      resp_t r;
      r.m2 = m2; r.rdata = rd; r.err = err; r.chk_rd = chk_rd;
      exp_q.push_back(r);
   endtask

   task automatic drive_m(input int m, input logic req, input logic vld, input logic md,
                          input logic [15:0] ad, input logic [7:0] wd);
      if (m == 1) begin
         m1_req = req; m1_valid = vld; m1_mode = md; m1_addr = ad; m1_wdata = wd;
      end else begin
         m2_req = req; m2_valid = vld; m2_mode = md; m2_addr = ad; m2_wdata = wd;
      end
   endtask

   // one clock; invariants and scoreboard pop at the falling edge
   task automatic step();
      resp_t r;
      @(negedge clk);
      saw_ready = {m2_ready, m1_ready};
      check("grant_onehot0", $onehot0({m1_grant, m2_grant}), 1);
      check("sel_onehot0", $onehot0({s1, s2, s3}), 1);
      check("ready_has_grant", {m2_ready & ~m2_grant, m1_ready & ~m1_grant}, 0);
      if (exp_q.size() == 0) begin
         check("spurious_ready", {m2_ready, m1_ready}, 0);
      end else if (m1_ready || m2_ready) begin
         r = exp_q.pop_front();
         check("resp_owner", {m2_ready, m1_ready}, r.m2 ? 2'b10 : 2'b01);
         check("resp_err", m_err, r.err);
         if (r.chk_rd) check("resp_rdata", m_rdata, r.rdata);
      end
   endtask

   task automatic wait_ready(input int max_cyc, output int n);
      n = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         step();
         if (saw_ready != 2'b00) begin
            n = i;
            return;
         end
      end
      check("ready_bound", saw_ready != 2'b00, 1);
   endtask

   initial begin
      // reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", all_outs(), 0);
      rst = 0;

      // single write to s1
      drive_m(1, 1, 1, 1, 16'h0001, 8'hFF);
      s1_rdata = 8'h33;
      push_exp(0, 8'h33, 0, 1);
      step();
      check("wr_grant", {m1_grant, m2_grant, valid, s1}, 4'b1000);
      step();
      check("wr_sel", {s3, s2, s1}, 3'b001);
      check("wr_valid", valid, 1);
      check("wr_bus", {mode, addr, wdata}, {1'b1, 16'h0001, 8'hFF});
      step();
      check("wr_hold_sel", {s1, valid, m1_ready}, 3'b110);
      s1_ready = 1;
      step();
      check("wr_ready", {m1_ready, valid, s1}, 3'b100);
      drive_m(1, 0, 0, 0, 16'h0000, 8'h00);
      s1_ready = 0;
      step();
      check("wr_grant_drop", {m1_grant, m2_grant}, 0);

      // read from s2 with stray readies from other slaves
      drive_m(2, 1, 1, 0, 16'h1004, 8'h00);
      s2_rdata = 8'h5A;
      s1_ready = 1;
      s3_ready = 1;
      push_exp(1, 8'h5A, 0, 1);
      step();
      check("rd_grant", {m1_grant, m2_grant}, 2'b01);
      step();
      check("rd_sel", {s3, s2, s1, valid}, 4'b0101);
      check("rd_bus", {mode, addr}, {1'b0, 16'h1004});
      step();
      check("rd_ignore_other_ready", {s3, s2, s1, m2_ready}, 4'b0100);
      s2_ready = 1;
      step();
      check("rd_ready_data", {m2_ready, m_rdata}, {1'b1, 8'h5A});
      drive_m(2, 0, 0, 0, 16'h0000, 8'h00);
      {s1_ready, s2_ready, s3_ready} = 3'b000;
      step();

      // round robin from reset with both masters requesting
      #2 rst = 1;
      @(negedge clk);
      rst = 0;
      s1_rdata = 8'h11; s2_rdata = 8'h22;
      s1_ready = 1; s2_ready = 1;
      drive_m(1, 1, 1, 0, 16'h0010, 8'h00);
      drive_m(2, 1, 1, 1, 16'h1020, 8'hAB);
      push_exp(0, 8'h11, 0, 1);
      push_exp(1, 8'h22, 0, 1);
      push_exp(0, 8'h11, 0, 1);
      push_exp(1, 8'h22, 0, 1);
      for (int k = 0; k < 4; k++) begin
         wait_ready(12, cyc);
         check("rr_spacing", cyc, (k == 0) ? 3 : 4);
      end
      drive_m(1, 0, 0, 0, 16'h0000, 8'h00);
      drive_m(2, 0, 0, 0, 16'h0000, 8'h00);
      step();
      step();
      check("rr_idle", {m1_grant, m2_grant}, 0);

      // decode error
      {s1_ready, s2_ready, s3_ready} = 3'b111;
      drive_m(1, 1, 1, 0, 16'h7000, 8'h00);
      push_exp(0, 8'h00, 1, 0);
      step();
      check("dec_grant", m1_grant, 1);
      step();
      check("dec_no_sel", {s3, s2, s1, valid}, 0);
      step();
      check("dec_ready_3rd", {m1_ready, m_err}, 2'b11);
      drive_m(1, 0, 0, 0, 16'h0000, 8'h00);
      {s1_ready, s2_ready, s3_ready} = 3'b000;
      step();
      step();
      check("err_hold", {m_err, m1_grant}, 2'b10);

      // access timeout, then a follow-up request
      s1_rdata = 8'hEE;
      drive_m(2, 1, 1, 0, 16'h0ABC, 8'h00);
      push_exp(1, 8'h00, 1, 1);
      for (int i = 1; i <= TIMEOUT + 1; i++) begin
         step();
         check("to_sel", {s3, s2, s1}, (i >= 2) ? 3'b001 : 3'b000);
         check("to_no_early_ready", m2_ready, 0);
      end
      step();
      check("to_ready_16", m2_ready, 1);
      drive_m(2, 0, 0, 0, 16'h0000, 8'h00);
      drive_m(1, 1, 1, 1, 16'h2000, 8'h5C);
      s3_rdata = 8'h77;
      s3_ready = 1;
      push_exp(0, 8'h77, 0, 1);
      wait_ready(12, cyc);
      check("served_after_timeout", cyc, 4);
      drive_m(1, 0, 0, 0, 16'h0000, 8'h00);
      s3_ready = 0;
      step();

      // asynchronous reset during ACCESS
      drive_m(2, 1, 1, 0, 16'h2345, 8'h00);
      step();
      step();
      check("rst_pre_sel", {s3, valid}, 2'b11);
      drive_m(1, 1, 1, 0, 16'h0001, 8'h00);
      #2 rst = 1;
      #1 check("rst_async_clear", all_outs(), 0);
      @(posedge clk);
      #1 check("rst_held_clear", all_outs(), 0);
      @(negedge clk);
      rst = 0;
      s1_rdata = 8'h44;
      s1_ready = 1;
      push_exp(0, 8'h44, 0, 1);
      step();
      check("rst_first_grant_m1", {m1_grant, m2_grant}, 2'b10);
      drive_m(2, 0, 0, 0, 16'h0000, 8'h00);
      wait_ready(12, cyc);
      check("rst_followup_latency", cyc, 2);
      drive_m(1, 0, 0, 0, 16'h0000, 8'h00);
      s1_ready = 0;
      step();
      step();
      check("end_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
